edge_pulser_array: RTL and testbench
====================================

// Module: edge_pulser_array
// PURPOSE
//  Multi-channel successor to the single-channel pulser. Each channel does three things:
//   - synchronises an asynchronous input (button, switch, UART line) to clk;
//   - debounces it with a per-channel stability counter;
//   - emits a one-clk pulse on the selected edge type.
//  Sits between board I/O and the transmitter/receiver control FSMs.
// PARAMETERS
//  WIDTH           4   number of independent channels (1..32)
//  SYNC_STAGES     2   synchroniser flops per channel (2..4)
//  DEBOUNCE_CYCLES 16  consecutive clk cycles a new level must hold before acceptance (>=1)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous reset, active-low
//  din        in   WIDTH  raw asynchronous inputs
//  mode       in   2      edge select, common to all channels: 00 rise, 01 fall, 10 both, 11 off
//  level      out  WIDTH  debounced, synchronised level per channel
//  pulse      out  WIDTH  one-cycle edge pulse per channel
//  any_pulse  out  1      registered OR of the pulse vector computed in the same cycle
//                         (same timing as pulse, not delayed)
// BEHAVIOUR
//  - Reset (rst=0, async): sync flops, level, counters, pulse, any_pulse all cleared to 0.
//    - Released synchronously on the next clk edge.
//  - Sync: din[i] passes through SYNC_STAGES flops. Call the last flop s[i].
//  - Debounce counter cnt[i]:
//    - width $clog2(DEBOUNCE_CYCLES)+1.
//    - If s[i]==level[i]: cnt[i] <= 0.
//    - Else if cnt[i]==DEBOUNCE_CYCLES-1: level[i] <= s[i] and cnt[i] <= 0 (accept).
//    - Else: cnt[i] <= cnt[i]+1.
//  - Glitches: any return to the old level before acceptance clears cnt. A glitch shorter
//    than DEBOUNCE_CYCLES cycles is never seen on level or pulse.
//  - Pulse: registered, asserted for exactly the one cycle following the accept edge.
//    - Accept 0->1: pulse when mode is 00 or 10.
//    - Accept 1->0: pulse when mode is 01 or 10.
//    - mode 11: pulse and any_pulse held 0, but level keeps tracking.
//  - Latency: din change captured at edge E0 -> level and pulse update at edge
//    E0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
//  - Pulse width: exactly 1 cycle. A held input never repeats the pulse.
//    - Minimum spacing between pulses on one channel is DEBOUNCE_CYCLES cycles.
//  - Mode change: takes effect at the next edge. Changing mode never generates a pulse by
//    itself. Mode is sampled on the accept edge.
//  - Channels are fully independent. Simultaneous accepts on several channels give
//    simultaneous pulses, and any_pulse is a single cycle.
//  - Reset mid-operation: in-flight counts are discarded.
//    - A channel held high through reset is re-accepted after full latency.
//    - That re-accept produces one rising pulse (mode 00/10).
//  - No combinational path from any input to any output.
// CONFIGURATION
//  EDGE_PULSER_COUNT_EN defined: adds ports
//    - clr        in   1  sync clear of the event counter
//    - event_cnt  out  8  total pulses across all channels; reset 0
//  Counter behaviour:
//    - Each cycle, event_cnt adds popcount(pulse), saturating at 255.
//    - clr has priority over increment. Same-cycle clr+pulse gives 0.
//  EDGE_PULSER_COUNT_EN not defined: clr and event_cnt do not exist; no counter logic.
// TESTING
//  1. WIDTH=4, SYNC=2, DEB=16, mode=00: din[0] 0->1 at edge 10 -> pulse[0]=1 only in cycle
//     after edge 27; level[0]=1 from edge 27; any_pulse matches.
//  2. Glitch: din[1] high for 15 cycles then low -> level[1], pulse[1] stay 0. High 16
//     cycles -> one pulse (mode 00), then one more on the fall only if mode=10.
//  3. mode=01 and mode=11: rising din[2] -> no pulse, level[2] goes 1; falling din[2] ->
//     pulse in 01, none in 11; switching mode while idle -> no pulse.
//  4. din[0] and din[3] rise on same edge -> pulse=4'b1001 for one cycle, any_pulse=1 for
//     one cycle; with EDGE_PULSER_COUNT_EN event_cnt increments by 2.
//  5. Assert rst mid-count (cnt=10) with din[0]=1 -> outputs 0 immediately (async).
//     Release -> rising pulse at full latency after release.
//  6. EDGE_PULSER_COUNT_EN: 300 pulses -> event_cnt=255 (saturate). clr with a pulse in
//     the same cycle -> event_cnt=0.

Source files
------------

// File: rtl/edge_pulser_array.sv
// edge_pulser_array: per-channel synchroniser, debouncer and edge pulser; EDGE_PULSER_COUNT_EN adds a saturating pulse counter
module edge_pulser_array #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
`ifdef EDGE_PULSER_COUNT_EN
  input  logic             clr,
  output logic [7:0]       event_cnt,
`endif
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse,
  output logic             any_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_level, r_pulse, w_s, w_acc, w_pulse;
  logic             r_any, w_rise_en, w_fall_en;
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise_en = (mode == 2'b00) || (mode == 2'b10);
  assign w_fall_en = (mode == 2'b01) || (mode == 2'b10);
  assign w_pulse   = ({WIDTH{w_rise_en}} & w_acc & w_s) | ({WIDTH{w_fall_en}} & w_acc & ~w_s);
  // shift raw inputs through the synchroniser chain, stage 0 first
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    assign w_acc[g] = (w_s[g] != r_level[g]) && (r_cnt == LAST);
    // count consecutive cycles the synchronised input disagrees with the accepted level
    always_ff @(posedge clk or negedge rst)
      if (!rst) r_cnt <= '0;
      else      r_cnt <= (w_s[g] == r_level[g] || w_acc[g]) ? '0 : r_cnt + CW'(1);
  end
  // accept new levels and register the edge pulses together
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_level <= '0;
      r_pulse <= '0;
      r_any   <= 1'b0;
    end else begin
      r_level <= r_level ^ w_acc;
      r_pulse <= w_pulse;
      r_any   <= |w_pulse;
    end
  assign level     = r_level;
  assign pulse     = r_pulse;
  assign any_pulse = r_any;
`ifdef EDGE_PULSER_COUNT_EN
  logic [7:0] r_evt;
  logic [8:0] w_sum;
  // running total plus this cycle's pulse count; 9 bits covers 255 + 32
  always_comb begin
    w_sum = 9'(r_evt);
    for (int j = 0; j < WIDTH; j++) w_sum = w_sum + 9'(r_pulse[j]);
  end
  // clear wins over increment; otherwise saturate at 255
  always_ff @(posedge clk or negedge rst)
    if (!rst)     r_evt <= '0;
    else if (clr) r_evt <= '0;
    else          r_evt <= (w_sum > 9'd255) ? 8'd255 : w_sum[7:0];
  assign event_cnt = r_evt;
`endif
endmodule

// File: tb/tb_edge_pulser_array.sv
// tb_edge_pulser_array: vector table, corner sequences and random stimulus against a history-window model
`timescale 1ns/1ps
module tb_edge_pulser_array;
  localparam int W = 4, SS = 2, DEB = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] din = '0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] level, pulse;
  logic any_pulse;
`ifdef EDGE_PULSER_COUNT_EN
  logic clr = 1'b0;
  logic [7:0] event_cnt;
`endif
  edge_pulser_array #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode),
`ifdef EDGE_PULSER_COUNT_EN
    .clr(clr), .event_cnt(event_cnt),
`endif
    .level(level), .pulse(pulse), .any_pulse(any_pulse));
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [W-1:0] h [SS+DEB];
  logic [W-1:0] m_level, m_pulse;
  logic m_any;
  int m_cnt;

  typedef struct packed {
    logic [W-1:0] din;
    logic [1:0]   mode;
    int           n;
    logic [W-1:0] lvl;
    logic [W-1:0] pls;
    logic         any;
  } vec_t;
  vec_t tv [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (h[k]) h[k] = '0;
    m_level = '0; m_pulse = '0; m_any = 1'b0; m_cnt = 0;
  endtask

  // a channel accepts when the last DEB synchronised samples all differ from its level
  task automatic model_edge();
    logic [W-1:0] a;
    a = '1;
    for (int k = 0; k < DEB; k++) a &= h[SS-1+k] ^ m_level;
`ifdef EDGE_PULSER_COUNT_EN
    if (clr) m_cnt = 0;
    else m_cnt = (m_cnt + $countones(m_pulse) > 255) ? 255 : m_cnt + $countones(m_pulse);
`endif
    m_pulse = (((mode == 2'b00) || (mode == 2'b10)) ? (a & ~m_level) : '0) |
              (((mode == 2'b01) || (mode == 2'b10)) ? (a & m_level) : '0);
    m_any = |m_pulse;
    m_level ^= a;
    for (int k = SS + DEB - 1; k > 0; k--) h[k] = h[k-1];
    h[0] = din;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_level", level, m_level);
    chk("model_pulse", pulse, m_pulse);
    chk("model_any", any_pulse, m_any);
`ifdef EDGE_PULSER_COUNT_EN
    chk("model_event_cnt", event_cnt, m_cnt);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_any", any_pulse, 0);
`ifdef EDGE_PULSER_COUNT_EN
    chk("rst_event_cnt", event_cnt, 0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();
    // din, mode, edges to run, then expected level, pulse, any_pulse
    tv.push_back('{4'b0001, 2'b00, 17, 4'b0000, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b00,  1, 4'b0001, 4'b0001, 1'b1});
    tv.push_back('{4'b0001, 2'b00,  1, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0011, 2'b00, 15, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b00, 20, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0011, 2'b00, 17, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0011, 2'b00,  1, 4'b0011, 4'b0010, 1'b1});
    tv.push_back('{4'b0001, 2'b00, 17, 4'b0011, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b00,  1, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0011, 2'b10, 18, 4'b0011, 4'b0010, 1'b1});
    tv.push_back('{4'b0001, 2'b10, 18, 4'b0001, 4'b0010, 1'b1});
    tv.push_back('{4'b0001, 2'b10,  1, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0101, 2'b01, 18, 4'b0101, 4'b0000, 1'b0});
    tv.push_back('{4'b0101, 2'b11,  3, 4'b0101, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b11, 18, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0101, 2'b01, 18, 4'b0101, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b01, 18, 4'b0001, 4'b0100, 1'b1});
    tv.push_back('{4'b0001, 2'b01,  1, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b10,  2, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0001, 2'b00,  2, 4'b0001, 4'b0000, 1'b0});
    tv.push_back('{4'b0000, 2'b00, 18, 4'b0000, 4'b0000, 1'b0});
    tv.push_back('{4'b1001, 2'b00, 18, 4'b1001, 4'b1001, 1'b1});
    tv.push_back('{4'b1001, 2'b00,  1, 4'b1001, 4'b0000, 1'b0});
    foreach (tv[i]) begin
      din = tv[i].din;
      mode = tv[i].mode;
      repeat (tv[i].n) step();
      chk($sformatf("tv%0d_level", i), level, tv[i].lvl);
      chk($sformatf("tv%0d_pulse", i), pulse, tv[i].pls);
      chk($sformatf("tv%0d_any", i), any_pulse, tv[i].any);
    end
    // reset in the middle of a count, then full-latency re-accept of held-high inputs
    din = 4'b1000;
    repeat (18) step();
    chk("pre_rst_level", level, 4'b1000);
    din = 4'b1001;
    repeat (11) step();
    #2;
    do_reset();
    repeat (17) step();
    chk("rst_no_early_pulse", pulse, 0);
    step();
    chk("rst_reaccept_pulse", pulse, 4'b1001);
    chk("rst_reaccept_any", any_pulse, 1);
    step();
    chk("rst_reaccept_once", pulse, 0);
`ifdef EDGE_PULSER_COUNT_EN
    mode = 2'b10;
    for (int i = 0; i < 80; i++) begin
      din = i[0] ? 4'h0 : 4'hF;
      repeat (18) step();
    end
    chk("cnt_saturate", event_cnt, 255);
    din = 4'hF;
    repeat (18) step();
    chk("cnt_clr_pulse_present", pulse, 4'hF);
    clr = 1'b1;
    step();
    chk("cnt_clr_priority", event_cnt, 0);
    clr = 1'b0;
    step();
    chk("cnt_after_clr", event_cnt, 0);
`endif
    for (int i = 0; i < 150; i++) begin
      din = W'($urandom);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
`ifdef EDGE_PULSER_COUNT_EN
      clr = ($urandom_range(0, 15) == 0);
`endif
      repeat ($urandom_range(1, 40)) step();
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
